manchester_deserializer: RTL and testbench
==========================================

Name: manchester_deserializer

Overview:
- Downstream of IDLEdetection in the Digital Control Unit.
- Decodes the oversampled balanced (Manchester) serial line `balancedCLK` into parallel words for the LED command register file.
- Uses IDLEdetection's `IDLE` flag to frame transfers.
- Uses the same `REF4Bits` reference as IDLEdetection (nominally 1.5 half-bit periods in clk cycles) to separate bit-boundary edges from mid-bit edges.

Parameters:
- DATA_W, 8, decoded word width; bits arrive MSB first.
- CNT_W, 5, run-length counter width; must hold 2*15 = 30.

Ports:
- clk  input  1  system oversampling clock
- globalResetN  input  1  asynchronous, active-low reset
- balancedCLK  input  1  raw Manchester line, asynchronous to clk
- IDLE  input  1  line-idle flag from IDLEdetection
- REF4Bits  input  4  edge-classification reference in clk cycles
- dataOut  output  DATA_W  last complete decoded word
- dataValid  output  1  one-cycle pulse when dataOut is updated
- frameError  output  1  one-cycle pulse on aborted or malformed frame
- busy  output  1  high while a frame is being decoded (state not S_WAIT)

Behaviour:
- Reset (globalResetN=0, async):
  - dataOut=0, dataValid=0, frameError=0, busy=0.
  - Shift register, bit counter and run counter cleared; state=S_WAIT.
- Input stage:
  - 2-flop synchronizer on balancedCLK, then a third flop for edge detect.
  - edge = sync2 ^ sync3.
  - Pin-to-edge latency is 3 cycles.
- Run counter `cnt`:
  - Clears to 0 on the cycle an accepted mid-bit edge is seen.
  - Otherwise increments, saturating at all-ones.
- Bit value rule: bit = sync2 level after the mid-bit edge (rising = 1, falling = 0).
- States:
  - S_WAIT: stay while IDLE=1 or REF4Bits<2. On IDLE=0 with REF4Bits>=2 go to S_SYNC.
  - S_SYNC: first edge is the mid-bit edge of a sync bit. Its value is discarded; cnt cleared; go to S_BLANK. IDLE=1 returns to S_WAIT with no error.
  - S_BLANK:
    - Edges ignored (bit-boundary edges).
    - When cnt reaches REF4Bits-1, go to S_WINDOW.
  - S_WINDOW:
    - An edge is a mid-bit edge: shift in the bit, increment bitCount, clear cnt, go to S_BLANK.
    - If cnt reaches 2*REF4Bits with no edge: frameError pulse, discard partial word, go to S_WAIT.
- Word completion:
  - When the DATA_W-th bit is shifted in, dataOut <= {shift[DATA_W-2:0], bit} on the next edge of clk.
  - dataValid pulses for 1 cycle; bitCount wraps to 0.
  - Decoding continues into the next word with no re-sync until IDLE.
- IDLE rising in S_BLANK/S_WINDOW:
  - bitCount != 0: frameError pulse, partial word discarded.
  - bitCount == 0: clean end, no pulse.
  - Either way go to S_WAIT.
- Simultaneous events:
  - IDLE=1 and a window edge in the same cycle: IDLE wins, edge ignored.
  - dataValid and frameError are never high in the same cycle.
- REF4Bits is sampled continuously; changing it mid-frame is illegal (behaviour undefined, but the FSM must not lock up; timeout still fires).
- dataOut holds its value until the next completed word; it is not cleared by frameError.

Decomposition:
- Shared package `dcu_pkg`:
  - state encoding localparams S_WAIT, S_SYNC, S_BLANK, S_WINDOW
  - DATA_W default
  - REF_MIN = 2
- One sub-module, `line_sync_edge`: 2-flop synchronizer plus edge detect, outputs sync level and edge pulse, same clk/globalResetN.

Test Plan (clk period 1 ns, REF4Bits=12, half-bit = 8 cycles, line low with IDLE=1 beforehand):
- Reset: assert globalResetN=0 for 3 cycles mid-activity -> all outputs 0, busy=0. After release, no decoding until IDLE has been seen high then low.
- Single word: IDLE falls, send sync bit then 0xA5 -> exactly one dataValid pulse, dataOut=8'hA5, frameError never asserts. dataValid occurs 4 cycles after the last mid-bit pin transition.
- Back-to-back words: send sync bit, 0x00, 0xFF with no gap -> two dataValid pulses 128 cycles apart, dataOut=8'h00 then 8'hFF.
- Early IDLE: send sync bit plus 3 bits, then force IDLE=1 -> one frameError pulse, no dataValid, busy falls, dataOut unchanged.
- Stuck line: after 2 data bits, hold the line constant for 40 cycles with IDLE=0 -> frameError pulse when cnt reaches 24 after the last mid-bit edge, FSM returns to S_WAIT.
- Invalid reference: REF4Bits=1, toggle the line with IDLE=0 -> busy stays 0, no dataValid, no frameError.

Source files
------------

// File: rtl/dcu_pkg.sv
// Shared definitions for the Digital Control Unit receive path.
// Holds the Manchester deserializer state encoding, the default decoded
// word width and the smallest edge-classification reference that still
// separates bit-boundary edges from mid-bit edges.
`timescale 1ns/1ps
package dcu_pkg;

   // Default width of a decoded LED command word.
   localparam int DCU_DATA_W = 8;

   // Any smaller reference leaves no room between the blanking interval and
   // the sampling window, so the decoder refuses to start a frame with it.
   localparam logic [3:0] REF_MIN = 4'd2;

   // Deserializer states. Plain constants keep the encoding stable for
   // older tools and for anyone probing the state register directly.
   localparam logic [1:0] S_WAIT   = 2'd0;
   localparam logic [1:0] S_SYNC   = 2'd1;
   localparam logic [1:0] S_BLANK  = 2'd2;
   localparam logic [1:0] S_WINDOW = 2'd3;

endpackage

// File: rtl/line_sync_edge.sv
// Brings the asynchronous balanced line into the clk domain and flags every
// transition of it.
// Ports:
//   clk          system oversampling clock
//   globalResetN asynchronous active-low reset
//   lineIn       raw line, asynchronous to clk
//   lineLevel    synchronized line level (second synchronizer flop)
//   lineEdge     high for one cycle after each synchronized transition
`timescale 1ns/1ps
module line_sync_edge (
   input  logic clk,
   input  logic globalResetN,
   input  logic lineIn,
   output logic lineLevel,
   output logic lineEdge
);

   logic sync1;
   logic sync2;
   logic sync3;

   // Two flops resolve metastability; the third holds the previous settled
   // level so a transition can be spotted by comparing neighbours.
   always_ff @(posedge clk or negedge globalResetN) begin
      if (!globalResetN) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= lineIn;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign lineLevel = sync2;
   assign lineEdge  = sync2 ^ sync3;

endmodule

// File: rtl/manchester_deserializer.sv
// Decodes the oversampled Manchester line into parallel words for the LED
// command register file. Frames are bounded by the IDLE flag; each frame
// starts with one sync bit whose mid-bit edge sets the bit phase, then data
// bits follow MSB first, with consecutive words packed back to back.
// Ports:
//   clk          system oversampling clock
//   globalResetN asynchronous active-low reset
//   balancedCLK  raw Manchester line, asynchronous to clk
//   IDLE         line-idle flag from IDLEdetection
//   REF4Bits     edge-classification reference (about 1.5 half-bit periods)
//   dataOut      last complete decoded word
//   dataValid    one-cycle pulse when dataOut is updated
//   frameError   one-cycle pulse on an aborted or malformed frame
//   busy         high while a frame is being decoded
`timescale 1ns/1ps
module manchester_deserializer
   import dcu_pkg::*;
#(
   parameter int DATA_W = DCU_DATA_W,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              globalResetN,
   input  logic              balancedCLK,
   input  logic              IDLE,
   input  logic [3:0]        REF4Bits,
   output logic [DATA_W-1:0] dataOut,
   output logic              dataValid,
   output logic              frameError,
   output logic              busy
);

   localparam int BC_W = $clog2(DATA_W);

   logic              lineLevel;
   logic              lineEdge;
   logic [1:0]        state;
   logic [1:0]        stateNext;
   logic [CNT_W-1:0]  cnt;
   logic [BC_W-1:0]   bitCount;
   logic [DATA_W-1:0] shiftReg;
   logic              wordPending;
   logic              idleSeen;
   logic              idleSeenNext;
   logic              midAccept;
   logic              takeBit;
   logic              abortFrame;
   logic              errNow;
   logic              lastBit;
   logic [CNT_W-1:0]  refExt;
   logic [CNT_W-1:0]  blankLimit;
   logic [CNT_W-1:0]  timeoutLimit;

   line_sync_edge uLineSync (
      .clk          (clk),
      .globalResetN (globalResetN),
      .lineIn       (balancedCLK),
      .lineLevel    (lineLevel),
      .lineEdge     (lineEdge)
   );

   // A zero reference wraps blankLimit to all-ones, which the saturating run
   // counter still reaches, so a bad mid-frame reference cannot lock us up.
   assign refExt       = CNT_W'(REF4Bits);
   assign blankLimit   = refExt - CNT_W'(1);
   assign timeoutLimit = refExt << 1;
   assign lastBit      = (bitCount == BC_W'(DATA_W - 1));
   assign busy         = (state != S_WAIT);

   // Next-state decisions. IDLE is checked before any edge so that a frame
   // end always takes priority over a bit arriving in the same cycle.
   // idleSeen arms the decoder only after the line has been reported idle,
   // so reset release or a timeout in the middle of traffic never starts
   // decoding at an arbitrary bit phase.
   always_comb begin
      stateNext    = state;
      idleSeenNext = idleSeen;
      midAccept    = 1'b0;
      takeBit      = 1'b0;
      abortFrame   = 1'b0;
      errNow       = 1'b0;
      case (state)
         S_WAIT: begin
            if (IDLE) begin
               idleSeenNext = 1'b1;
            end else if (idleSeen && (REF4Bits >= REF_MIN)) begin
               stateNext    = S_SYNC;
               idleSeenNext = 1'b0;
            end
         end
         S_SYNC: begin
            if (IDLE) begin
               stateNext = S_WAIT;
            end else if (lineEdge) begin
               midAccept = 1'b1;
               stateNext = S_BLANK;
            end
         end
         S_BLANK: begin
            if (IDLE) begin
               stateNext  = S_WAIT;
               abortFrame = 1'b1;
               errNow     = (bitCount != '0);
            end else if (cnt >= blankLimit) begin
               stateNext = S_WINDOW;
            end
         end
         S_WINDOW: begin
            if (IDLE) begin
               stateNext  = S_WAIT;
               abortFrame = 1'b1;
               errNow     = (bitCount != '0);
            end else if (lineEdge) begin
               midAccept = 1'b1;
               takeBit   = 1'b1;
               stateNext = S_BLANK;
            end else if (cnt >= timeoutLimit) begin
               stateNext  = S_WAIT;
               abortFrame = 1'b1;
               errNow     = 1'b1;
            end
         end
         default: begin
            stateNext = S_WAIT;
         end
      endcase
   end

   // Frame state and the run-length counter that times the blanking
   // interval and the window timeout from the last accepted mid-bit edge.
   always_ff @(posedge clk or negedge globalResetN) begin
      if (!globalResetN) begin
         state    <= S_WAIT;
         idleSeen <= 1'b0;
         cnt      <= '0;
      end else begin
         state    <= stateNext;
         idleSeen <= idleSeenNext;
         if (midAccept) begin
            cnt <= '0;
         end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // Bit assembly. The completed word lands in shiftReg on the cycle its
   // last bit is taken and is copied to dataOut one cycle later through
   // wordPending. An abort only clears the partial word; dataOut keeps the
   // last good word.
   always_ff @(posedge clk or negedge globalResetN) begin
      if (!globalResetN) begin
         shiftReg    <= '0;
         bitCount    <= '0;
         wordPending <= 1'b0;
         dataOut     <= '0;
         dataValid   <= 1'b0;
         frameError  <= 1'b0;
      end else begin
         wordPending <= 1'b0;
         dataValid   <= 1'b0;
         frameError  <= errNow;
         if (wordPending) begin
            dataOut   <= shiftReg;
            dataValid <= 1'b1;
         end
         if (abortFrame || (midAccept && !takeBit)) begin
            shiftReg <= '0;
            bitCount <= '0;
         end else if (takeBit) begin
            shiftReg <= {shiftReg[DATA_W-2:0], lineLevel};
            if (lastBit) begin
               bitCount    <= '0;
               wordPending <= 1'b1;
            end else begin
               bitCount <= bitCount + BC_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_manchester_deserializer.sv
// Scoreboard bench for the Manchester deserializer. Stimulus drives the
// line at negedges with a half-bit of 8 clk cycles and REF4Bits=12, pushing
// the expected dataValid/frameError events before they are due; a separate
// monitor pops and compares each event as the DUT presents it, including
// its latency from the stimulus anchor cycle.
`timescale 1ns/1ps
module tb_manchester_deserializer;

   typedef struct {
      bit         isError;
      logic [7:0] data;
      int         delay;
   } expItem_t;

   logic       clk;
   logic       globalResetN;
   logic       balancedCLK;
   logic       IDLE;
   logic [3:0] REF4Bits;
   logic [7:0] dataOut;
   logic       dataValid;
   logic       frameError;
   logic       busy;

   int         total;
   int         bad;
   int         cycle;
   int         anchor;
   bit         sawBusy;
   expItem_t   expQ[$];

   manchester_deserializer dut (
      .clk          (clk),
      .globalResetN (globalResetN),
      .balancedCLK  (balancedCLK),
      .IDLE         (IDLE),
      .REF4Bits     (REF4Bits),
      .dataOut      (dataOut),
      .dataValid    (dataValid),
      .frameError   (frameError),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #0.5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Monitor: every output event must match the oldest expectation in kind,
   // data and latency from the anchor cycle recorded by the stimulus.
   always @(negedge clk) begin
      if (globalResetN && (dataValid || frameError)) begin
         total++;
         if (dataValid && frameError) begin
            bad++;
            $display("[TB] FAIL event: dataValid and frameError both high at cycle %0d", cycle);
         end else if (expQ.size() == 0) begin
            bad++;
            $display("[TB] FAIL event: unexpected %s at cycle %0d, dataOut=%0h, nothing expected",
                     dataValid ? "dataValid" : "frameError", cycle, dataOut);
         end else begin
            expItem_t item;
            item = expQ.pop_front();
            if ((item.isError != frameError) ||
                (!item.isError && (dataOut !== item.data)) ||
                ((cycle - anchor) != item.delay)) begin
               bad++;
               $display("[TB] FAIL event: got %s data=%0h delay=%0d, expected %s data=%0h delay=%0d",
                        frameError ? "frameError" : "dataValid", dataOut, cycle - anchor,
                        item.isError ? "frameError" : "dataValid", item.data, item.delay);
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic pushExp(input bit isError, input logic [7:0] data, input int delay);
      expItem_t item;
      item.isError = isError;
      item.data    = data;
      item.delay   = delay;
      expQ.push_back(item);
   endtask

   task automatic driveHalf(input logic level);
      balancedCLK = level;
      repeat (8) @(negedge clk);
   endtask

   // Manchester bit: first half is the complement, the mid-bit transition
   // lands on the bit value.
   task automatic sendBit(input logic b);
      driveHalf(~b);
      anchor = cycle;
      driveHalf(b);
   endtask

   task automatic applyStimulus(input logic [7:0] word);
      for (int i = 7; i >= 0; i--) sendBit(word[i]);
   endtask

   task automatic startFrame();
      IDLE        = 1'b1;
      balancedCLK = 1'b0;
      repeat (10) @(negedge clk);
      IDLE = 1'b0;
      repeat (3) @(negedge clk);
      sendBit(1'b1);
   endtask

   task automatic endFrame();
      IDLE   = 1'b1;
      anchor = cycle;
      repeat (5) @(negedge clk);
   endtask

   task automatic toggleWatch(input int n);
      for (int i = 0; i < n; i++) begin
         balancedCLK = ~balancedCLK;
         repeat (8) begin
            @(negedge clk);
            if (busy) sawBusy = 1'b1;
         end
      end
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      cycle        = 0;
      anchor       = 0;
      globalResetN = 1'b0;
      IDLE         = 1'b1;
      balancedCLK  = 1'b0;
      REF4Bits     = 4'd12;
      repeat (3) @(negedge clk);
      checkOutput("reset dataOut", 32'(dataOut), 32'h0);
      checkOutput("reset dataValid", 32'(dataValid), 32'h0);
      checkOutput("reset frameError", 32'(frameError), 32'h0);
      checkOutput("reset busy", 32'(busy), 32'h0);
      globalResetN = 1'b1;
      repeat (10) @(negedge clk);

      $display("[TB] single word 0xA5");
      pushExp(1'b0, 8'hA5, 4);
      startFrame();
      checkOutput("busy in frame", 32'(busy), 32'h1);
      applyStimulus(8'hA5);
      endFrame();
      checkOutput("busy after clean end", 32'(busy), 32'h0);
      checkOutput("dataOut A5", 32'(dataOut), 32'hA5);

      $display("[TB] back-to-back 0x00 0xFF");
      pushExp(1'b0, 8'h00, 4);
      pushExp(1'b0, 8'hFF, 4);
      startFrame();
      applyStimulus(8'h00);
      applyStimulus(8'hFF);
      endFrame();
      checkOutput("dataOut FF", 32'(dataOut), 32'hFF);

      $display("[TB] early IDLE after 3 bits");
      startFrame();
      sendBit(1'b1);
      sendBit(1'b0);
      sendBit(1'b1);
      pushExp(1'b1, 8'h00, 1);
      endFrame();
      checkOutput("busy after early IDLE", 32'(busy), 32'h0);
      checkOutput("dataOut kept after abort", 32'(dataOut), 32'hFF);

      $display("[TB] stuck line after 2 bits");
      startFrame();
      sendBit(1'b1);
      sendBit(1'b0);
      pushExp(1'b1, 8'h00, 28);
      repeat (32) @(negedge clk);
      checkOutput("busy after timeout", 32'(busy), 32'h0);
      checkOutput("dataOut kept after timeout", 32'(dataOut), 32'hFF);

      $display("[TB] reset mid-frame");
      startFrame();
      sendBit(1'b0);
      globalResetN = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("mid reset dataOut", 32'(dataOut), 32'h0);
      checkOutput("mid reset busy", 32'(busy), 32'h0);
      globalResetN = 1'b1;
      sawBusy = 1'b0;
      toggleWatch(12);
      checkOutput("no decode before IDLE", 32'(sawBusy), 32'h0);

      $display("[TB] invalid reference");
      REF4Bits    = 4'd1;
      IDLE        = 1'b1;
      balancedCLK = 1'b0;
      repeat (10) @(negedge clk);
      IDLE    = 1'b0;
      sawBusy = 1'b0;
      toggleWatch(20);
      checkOutput("busy with REF4Bits=1", 32'(sawBusy), 32'h0);
      REF4Bits = 4'd12;

      $display("[TB] recovery word 0x3C");
      pushExp(1'b0, 8'h3C, 4);
      startFrame();
      applyStimulus(8'h3C);
      endFrame();
      checkOutput("dataOut 3C", 32'(dataOut), 32'h3C);

      repeat (20) @(negedge clk);
      checkOutput("expected events left", 32'(expQ.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
